// File: rtl/axi_tg_pkg.sv
// Shared types and AXI encodings for the DDR traffic-generator master.
package axi_tg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StWrResp,
    StRdAddr,
    StRdData,
    StDone
  } tg_state_e;

  localparam logic [2:0] AXI_SIZE_64B   = 3'd6;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_tg_pattern.sv
// Expected 512-bit beat payload: the low address word XOR seed, replicated 16 times.
module axi_tg_pattern #(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic [31:0]  beat_addr_i,
  output logic [511:0] data_o
);

  assign data_o = {16{beat_addr_i ^ SEED}};

endmodule

// File: rtl/axi_ddr_tg_master.sv
// AXI4 traffic generator: writes NUM_BURSTS patterned bursts, reads them back and counts errors.
module axi_ddr_tg_master
  import axi_tg_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int unsigned NUM_BURSTS = 16,
  parameter logic [7:0]  BURST_LEN  = 8'd7,
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic         clk_core,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_cnt,
  output logic [63:0]  err_addr,
  output logic [15:0]  cl_sh_ddr_awid,
  output logic [63:0]  cl_sh_ddr_awaddr,
  output logic [7:0]   cl_sh_ddr_awlen,
  output logic [2:0]   cl_sh_ddr_awsize,
  output logic [1:0]   cl_sh_ddr_awburst,
  output logic         cl_sh_ddr_awvalid,
  input  logic         sh_cl_ddr_awready,
  output logic [511:0] cl_sh_ddr_wdata,
  output logic [63:0]  cl_sh_ddr_wstrb,
  output logic         cl_sh_ddr_wlast,
  output logic         cl_sh_ddr_wvalid,
  input  logic         sh_cl_ddr_wready,
  input  logic [15:0]  sh_cl_ddr_bid,
  input  logic [1:0]   sh_cl_ddr_bresp,
  input  logic         sh_cl_ddr_bvalid,
  output logic         cl_sh_ddr_bready,
  output logic [15:0]  cl_sh_ddr_arid,
  output logic [63:0]  cl_sh_ddr_araddr,
  output logic [7:0]   cl_sh_ddr_arlen,
  output logic [2:0]   cl_sh_ddr_arsize,
  output logic [1:0]   cl_sh_ddr_arburst,
  output logic         cl_sh_ddr_arvalid,
  input  logic         sh_cl_ddr_arready,
  input  logic [15:0]  sh_cl_ddr_rid,
  input  logic [511:0] sh_cl_ddr_rdata,
  input  logic [1:0]   sh_cl_ddr_rresp,
  input  logic         sh_cl_ddr_rlast,
  input  logic         sh_cl_ddr_rvalid,
  output logic         cl_sh_ddr_rready
);

  localparam logic [63:0] Stride    = (64'(BURST_LEN) + 64'd1) << 6;
  localparam logic [63:0] BeatBytes = 64'd64;
  localparam logic [15:0] LastIdx   = 16'(NUM_BURSTS - 1);

  tg_state_e    state_q;
  logic [15:0]  idx_q;
  logic [7:0]   beat_q;
  logic [63:0]  burst_addr_q, beat_addr_q;
  logic         awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q, done_q;
  logic [15:0]  err_cnt_q;
  logic [63:0]  err_addr_q;
  logic [511:0] exp_data;
  logic         b_err, r_err, err_hit;
  logic [63:0]  err_loc;

  axi_tg_pattern #(
    .SEED(SEED)
  ) u_pattern (
    .beat_addr_i(beat_addr_q[31:0]),
    .data_o     (exp_data)
  );

  always_comb begin
    b_err   = (sh_cl_ddr_bresp != AXI_RESP_OKAY) || (sh_cl_ddr_bid != idx_q);
    r_err   = (sh_cl_ddr_rdata != exp_data) || (sh_cl_ddr_rresp != AXI_RESP_OKAY) ||
              (sh_cl_ddr_rid != idx_q) || (sh_cl_ddr_rlast != (beat_q == BURST_LEN));
    err_hit = ((state_q == StWrResp) && sh_cl_ddr_bvalid && bready_q && b_err) ||
              ((state_q == StRdData) && sh_cl_ddr_rvalid && rready_q && r_err);
    // A write response has no beat of its own; blame the burst start address.
    err_loc = (state_q == StWrResp) ? burst_addr_q : beat_addr_q;
  end

  always_ff @(posedge clk_core) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      beat_q       <= '0;
      burst_addr_q <= '0;
      beat_addr_q  <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      done_q       <= 1'b0;
      err_cnt_q    <= '0;
      err_addr_q   <= '0;
    end else begin
      if (err_hit) begin
        if (err_cnt_q == 16'h0000) err_addr_q <= err_loc;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q      <= StWrAddr;
            idx_q        <= '0;
            burst_addr_q <= BASE_ADDR;
            done_q       <= 1'b0;
            err_cnt_q    <= '0;
            err_addr_q   <= '0;
          end
        end
        StWrAddr: begin
          if (!awvalid_q) begin
            awvalid_q <= 1'b1;
          end else if (sh_cl_ddr_awready) begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b1;
            wlast_q     <= (BURST_LEN == 8'd0);
            beat_q      <= '0;
            beat_addr_q <= burst_addr_q;
            state_q     <= StWrData;
          end
        end
        StWrData: begin
          if (sh_cl_ddr_wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= StWrResp;
            end else begin
              beat_q      <= beat_q + 8'd1;
              beat_addr_q <= beat_addr_q + BeatBytes;
              wlast_q     <= ((beat_q + 8'd1) == BURST_LEN);
            end
          end
        end
        StWrResp: begin
          if (sh_cl_ddr_bvalid) begin
            bready_q <= 1'b0;
            if (idx_q == LastIdx) begin
              idx_q        <= '0;
              burst_addr_q <= BASE_ADDR;
              state_q      <= StRdAddr;
            end else begin
              idx_q        <= idx_q + 16'd1;
              burst_addr_q <= burst_addr_q + Stride;
              state_q      <= StWrAddr;
            end
          end
        end
        StRdAddr: begin
          if (!arvalid_q) begin
            arvalid_q <= 1'b1;
          end else if (sh_cl_ddr_arready) begin
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b1;
            beat_q      <= '0;
            beat_addr_q <= burst_addr_q;
            state_q     <= StRdData;
          end
        end
        StRdData: begin
          if (sh_cl_ddr_rvalid) begin
            beat_q      <= beat_q + 8'd1;
            beat_addr_q <= beat_addr_q + BeatBytes;
            if (sh_cl_ddr_rlast) begin
              rready_q <= 1'b0;
              if (idx_q == LastIdx) begin
                done_q  <= 1'b1;
                state_q <= StDone;
              end else begin
                idx_q        <= idx_q + 16'd1;
                burst_addr_q <= burst_addr_q + Stride;
                state_q      <= StRdAddr;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy              = (state_q != StIdle) && (state_q != StDone);
  assign done              = done_q;
  assign pass              = done_q && (err_cnt_q == 16'h0000);
  assign err_cnt           = err_cnt_q;
  assign err_addr          = err_addr_q;
  assign cl_sh_ddr_awid    = idx_q;
  assign cl_sh_ddr_awaddr  = burst_addr_q;
  assign cl_sh_ddr_awlen   = BURST_LEN;
  assign cl_sh_ddr_awsize  = AXI_SIZE_64B;
  assign cl_sh_ddr_awburst = AXI_BURST_INCR;
  assign cl_sh_ddr_awvalid = awvalid_q;
  assign cl_sh_ddr_wdata   = wvalid_q ? exp_data : '0;
  assign cl_sh_ddr_wstrb   = '1;
  assign cl_sh_ddr_wlast   = wlast_q;
  assign cl_sh_ddr_wvalid  = wvalid_q;
  assign cl_sh_ddr_bready  = bready_q;
  assign cl_sh_ddr_arid    = idx_q;
  assign cl_sh_ddr_araddr  = burst_addr_q;
  assign cl_sh_ddr_arlen   = BURST_LEN;
  assign cl_sh_ddr_arsize  = AXI_SIZE_64B;
  assign cl_sh_ddr_arburst = AXI_BURST_INCR;
  assign cl_sh_ddr_arvalid = arvalid_q;
  assign cl_sh_ddr_rready  = rready_q;

endmodule
